// File: rtl/if_fetch_unit_pkg.sv
// ============================================================================
//  Module      : if_fetch_unit_pkg
//  Description : Shared types and constants for the instruction fetch unit:
//                FSM state encoding, word widths, PC increment, and the
//                PC/instruction pair carried by the output and skid stages.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package if_fetch_unit_pkg;

    localparam int INSTR_W = 32;
    localparam int PAIR_W  = 2 * INSTR_W;

    localparam logic [INSTR_W-1:0] PC_INC = 32'd4;

    // Fetch sequencer states; the encoding width is explicit.
    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    // Pair handed to the IF/ID register: address of the next instruction
    // (fetch address + 4) and the fetched word.
    typedef struct packed {
        logic [INSTR_W-1:0] pc;
        logic [INSTR_W-1:0] instr;
    } fetch_pair_t;

    // Redirect targets are always word aligned; the low two bits are dropped.
    function automatic logic [INSTR_W-1:0] align_word(input logic [INSTR_W-1:0] a);
        return a & ~32'h0000_0003;
    endfunction

endpackage

`default_nettype wire

// File: rtl/if_fetch_unit_if.sv
// ============================================================================
//  Module      : if_fetch_unit_if
//  Description : Instruction-memory request/response bundle. The fetch unit
//                uses the master view, the memory model uses the slave view.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface if_fetch_unit_if;
    import if_fetch_unit_pkg::*;

    logic               imem_req;
    logic [INSTR_W-1:0] imem_addr;
    logic               imem_gnt;
    logic               imem_rvalid;
    logic [INSTR_W-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_gnt,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_gnt,
        output imem_rvalid,
        output imem_rdata
    );

endinterface

`default_nettype wire

// File: rtl/if_fetch_unit_skid_buf.sv
// ============================================================================
//  Module      : if_skid_buf
//  Description : One-entry skid buffer holding a PC/instruction pair that
//                arrived while the output register was stalled.
//                Priority: clear > load > unload.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module if_skid_buf
    import if_fetch_unit_pkg::*;
(
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              i_load,
    input  wire logic              i_unload,
    input  wire logic              i_clear,
    input  wire logic [PAIR_W-1:0] i_din,
    output logic      [PAIR_W-1:0] o_dout,
    output logic                   o_full
);

    logic              r_full;
    logic [PAIR_W-1:0] r_data;

    // Occupancy flag and payload; a redirect empties the entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_full <= 1'b0;
            r_data <= '0;
        end else if (i_clear) begin
            r_full <= 1'b0;
        end else if (i_load) begin
            r_full <= 1'b1;
            r_data <= i_din;
        end else if (i_unload) begin
            r_full <= 1'b0;
        end
    end

    assign o_dout = r_data;
    assign o_full = r_full;

endmodule

`default_nettype wire

// File: rtl/if_fetch_unit.sv
// ============================================================================
//  Module      : if_fetch_unit
//  Description : Single-outstanding instruction fetch stage. Issues one
//                memory request at a time, registers the PC/instruction pair
//                toward IF/ID, parks one response in a skid buffer under
//                stall, and handles branch redirects including draining an
//                in-flight response that belongs to the old path.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter logic [INSTR_W-1:0] RESET_PC = 32'h0000_0000
)(
    input  wire logic               clk,
    input  wire logic               rst,
    if_fetch_unit_if.master         imem,
    input  wire logic               br_taken,
    input  wire logic [INSTR_W-1:0] br_target,
    input  wire logic               stall,
    output logic                    out_valid,
    output logic      [INSTR_W-1:0] PC,
    output logic      [INSTR_W-1:0] Instruction
);

    fetch_state_t       r_state;
    fetch_state_t       w_next_state;
    logic [INSTR_W-1:0] r_fetch_pc;
    logic               r_out_valid;
    logic [INSTR_W-1:0] r_pc;
    logic [INSTR_W-1:0] r_instr;

    logic               w_skid_full;
    fetch_pair_t        w_skid_in;
    fetch_pair_t        w_skid_out;

    logic               w_grant;
    logic               w_rsp_accept;
    logic               w_consume;
    logic               w_load_out;
    logic               w_skid_load;
    logic               w_skid_unload;
    logic [INSTR_W-1:0] w_pc_plus;
    logic [INSTR_W-1:0] w_br_pc;

    // A grant only counts while a request is actually being driven.
    assign w_grant       = imem.imem_req && imem.imem_gnt;
    // Responses are honoured only in WAIT and only if no redirect kills them.
    assign w_rsp_accept  = (r_state == WAIT) && imem.imem_rvalid && !br_taken;
    assign w_consume     = r_out_valid && !stall;
    assign w_load_out    = w_rsp_accept && (!r_out_valid || !stall);
    assign w_skid_load   = w_rsp_accept && r_out_valid && stall;
    assign w_skid_unload = w_consume && w_skid_full && !br_taken;
    assign w_pc_plus     = r_fetch_pc + PC_INC;
    assign w_br_pc       = align_word(br_target);
    assign w_skid_in     = '{pc: w_pc_plus, instr: imem.imem_rdata};

    if_skid_buf u_skid (
        .clk      (clk),
        .rst      (rst),
        .i_load   (w_skid_load),
        .i_unload (w_skid_unload),
        .i_clear  (br_taken),
        .i_din    (w_skid_in),
        .o_dout   (w_skid_out),
        .o_full   (w_skid_full)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next-state: a granted request moves to WAIT, or to DRAIN if it is
    // already stale because of a same-cycle redirect.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            FETCH: begin
                if (w_grant) begin
                    w_next_state = br_taken ? DRAIN : WAIT;
                end
            end
            WAIT: begin
                if (imem.imem_rvalid) begin
                    w_next_state = FETCH;
                end else if (br_taken) begin
                    w_next_state = DRAIN;
                end
            end
            DRAIN: begin
                if (imem.imem_rvalid) begin
                    w_next_state = FETCH;
                end
            end
            default: w_next_state = FETCH;
        endcase
    end

    // FSM outputs: request only while fetching and the skid has room.
    always_comb begin
        imem.imem_req  = (r_state == FETCH) && !w_skid_full;
        imem.imem_addr = r_fetch_pc;
    end

    // Fetch address: redirect wins, otherwise advance on an accepted response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetch_pc <= RESET_PC;
        end else if (br_taken) begin
            r_fetch_pc <= w_br_pc;
        end else if (w_rsp_accept) begin
            r_fetch_pc <= w_pc_plus;
        end
    end

    // Output register toward IF/ID; a fresh response beats a skid refill,
    // which beats simply emptying after consumption.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_pc        <= '0;
            r_instr     <= '0;
        end else if (br_taken) begin
            r_out_valid <= 1'b0;
        end else if (w_load_out) begin
            r_out_valid <= 1'b1;
            r_pc        <= w_pc_plus;
            r_instr     <= imem.imem_rdata;
        end else if (w_skid_unload) begin
            r_out_valid <= 1'b1;
            r_pc        <= w_skid_out.pc;
            r_instr     <= w_skid_out.instr;
        end else if (w_consume) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid   = r_out_valid;
    assign PC          = r_pc;
    assign Instruction = r_instr;

endmodule

`default_nettype wire

// File: tb/tb_if_fetch_unit.sv
// ============================================================================
//  Module      : tb_if_fetch_unit
//  Description : Self-checking bench for if_fetch_unit. A memory model answers
//                requests with address-derived words; a scoreboard queue holds
//                the instruction stream expected from the current path and a
//                monitor pops it on every consumed output.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_if_fetch_unit;
    import if_fetch_unit_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        br_taken;
    logic [31:0] br_target;
    logic        stall;
    logic        out_valid;
    logic [31:0] PC;
    logic [31:0] Instruction;

    if_fetch_unit_if bus ();

    if_fetch_unit #(.RESET_PC(RST_PC)) dut (
        .clk         (clk),
        .rst         (rst),
        .imem        (bus.master),
        .br_taken    (br_taken),
        .br_target   (br_target),
        .stall       (stall),
        .out_valid   (out_valid),
        .PC          (PC),
        .Instruction (Instruction)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cycle    = 0;

    always @(posedge clk) cycle <= cycle + 1;

    // Instruction memory contents: a fixed scramble of the address.
    function automatic logic [31:0] word_at(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // ---------------- scoreboard: expected program-order stream ----------------
    exp_t        sb[$];
    logic [31:0] sb_next;

    task automatic sb_fill();
        while (sb.size() < 16) begin
            sb.push_back('{pc: sb_next + 32'd4, instr: word_at(sb_next)});
            sb_next = sb_next + 32'd4;
        end
    endtask

    task automatic sb_restart(input logic [31:0] a);
        sb.delete();
        sb_next = a;
        sb_fill();
    endtask

    // ---------------- memory model ----------------
    int          gnt_pct   = 100;
    int          max_delay = 1;
    bit          mem_en    = 1'b0;
    int          pend_cnt  = 0;
    logic [31:0] pend_addr = '0;

    initial begin
        bus.imem_gnt    = 1'b0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = '0;
        forever begin
            @(negedge clk);
            bus.imem_rvalid = 1'b0;
            if (pend_cnt > 0) begin
                pend_cnt--;
                if (pend_cnt == 0) begin
                    bus.imem_rvalid = 1'b1;
                    bus.imem_rdata  = word_at(pend_addr);
                end
            end
            if (bus.imem_req === 1'b1) begin
                bus.imem_gnt = 1'b0;
                if (mem_en && pend_cnt == 0 && ($urandom % 100) < gnt_pct) begin
                    bus.imem_gnt = 1'b1;
                    pend_addr    = bus.imem_addr;
                    pend_cnt     = $urandom_range(max_delay, 1);
                end
            end else begin
                // Grant is meaningless without a request; toggle it as noise.
                bus.imem_gnt = ($urandom % 2) == 1;
            end
        end
    end

    // ---------------- monitor ----------------
    bit   br_prev = 1'b0;
    int   cons_cyc[$];
    int   n_consumed = 0;
    exp_t e;

    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (rst === 1'b1) begin
                br_prev = 1'b0;
            end else begin
                if (br_prev) begin
                    checks++;
                    if (out_valid !== 1'b0) begin
                        failures++;
                        $display("FAIL valid_after_branch: got %b expected 0", out_valid);
                    end
                end
                if (out_valid === 1'b1 && stall === 1'b0) begin
                    checks++;
                    n_consumed++;
                    cons_cyc.push_back(cycle);
                    if (sb.size() == 0) begin
                        failures++;
                        $display("FAIL output_pair: got %h/%h expected none", PC, Instruction);
                    end else begin
                        e = sb.pop_front();
                        if (PC !== e.pc || Instruction !== e.instr) begin
                            failures++;
                            $display("FAIL output_pair: got %h/%h expected %h/%h",
                                     PC, Instruction, e.pc, e.instr);
                        end
                    end
                end
                br_prev = (br_taken === 1'b1);
            end
        end
    end

    // ---------------- stimulus ----------------
    // st: 0/1 fixed stall, 2 = stall whenever output is valid.
    // br_mode: 0 none, 1 redirect now, 2 redirect only on a response cycle.
    task automatic step(input int st, input int br_mode, input logic [31:0] tgt);
        @(negedge clk);
        #1;
        stall     = (st == 2) ? (out_valid === 1'b1) : (st == 1);
        br_target = tgt;
        br_taken  = (br_mode == 1) || (br_mode == 2 && bus.imem_rvalid === 1'b1);
        #2;
        if (br_taken) sb_restart(align_word(tgt));
        else          sb_fill();
    endtask

    task automatic wait_req_addr(input string nm, input logic [31:0] exp);
        bit seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            step(0, 0, 32'h0);
            if (bus.imem_req === 1'b1) begin
                seen = 1'b1;
                check(nm, bus.imem_addr, exp);
            end
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL %s: got no request expected addr %h", nm, exp);
        end
    endtask

    task automatic release_reset();
        @(negedge clk);
        #1;
        rst = 1'b0;
        sb_restart(RST_PC);
        check("reset_release_addr", bus.imem_addr, RST_PC);
    endtask

    logic [31:0] hold_pc;
    int          guard;
    int          n_before;
    logic [31:0] tgt;

    initial begin
        rst       = 1'b1;
        stall     = 1'b0;
        br_taken  = 1'b0;
        br_target = '0;
        sb_restart(RST_PC);

        repeat (3) @(negedge clk);
        #1;
        check("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check("reset_pc", PC, 32'd0);
        check("reset_instr", Instruction, 32'd0);
        check("reset_req", {31'd0, bus.imem_req}, 32'd1);
        release_reset();
        mem_en = 1'b1;

        // Back-to-back fetch, single-cycle memory, no stall.
        gnt_pct   = 100;
        max_delay = 1;
        cons_cyc.delete();
        repeat (12) step(0, 0, 32'h0);
        if (cons_cyc.size() < 3) begin
            checks++;
            failures++;
            $display("FAIL throughput: got %0d outputs expected >= 3", cons_cyc.size());
        end else begin
            check("throughput_gap1", cons_cyc[1] - cons_cyc[0], 32'd2);
            check("throughput_gap2", cons_cyc[2] - cons_cyc[1], 32'd2);
        end

        // Stall six cycles once an output is presented.
        guard = 0;
        do begin
            step(2, 0, 32'h0);
            guard++;
        end while (stall !== 1'b1 && guard < 20);
        check("stall_started", {31'd0, stall}, 32'd1);
        hold_pc = (sb.size() > 0) ? sb[0].pc : 32'hDEAD_BEEF;
        repeat (5) step(1, 0, 32'h0);
        check("stall_hold_pc", PC, hold_pc);
        check("stall_no_req", {31'd0, bus.imem_req}, 32'd0);
        check("stall_valid", {31'd0, out_valid}, 32'd1);
        repeat (8) step(0, 0, 32'h0);

        // Redirect while a response is outstanding.
        max_delay = 3;
        guard = 0;
        do begin
            step(0, 0, 32'h0);
            guard++;
        end while (pend_cnt < 2 && guard < 40);
        step(0, 1, 32'h0000_0103);
        wait_req_addr("branch_wait_addr", 32'h0000_0100);
        repeat (8) step(0, 0, 32'h0);

        // Redirect in the same cycle as a response.
        max_delay = 1;
        guard = 0;
        do begin
            step(0, 2, 32'h0000_0200);
            guard++;
        end while (br_taken !== 1'b1 && guard < 20);
        check("branch_rvalid_hit", {31'd0, br_taken}, 32'd1);
        wait_req_addr("branch_rvalid_addr", 32'h0000_0200);
        repeat (6) step(0, 0, 32'h0);

        // Address wrap at the top of the space.
        step(0, 1, 32'hFFFF_FFFC);
        wait_req_addr("wrap_first_addr", 32'hFFFF_FFFC);
        wait_req_addr("wrap_next_addr", 32'h0000_0000);
        repeat (6) step(0, 0, 32'h0);

        // Asynchronous reset while waiting for a response.
        max_delay = 3;
        guard = 0;
        do begin
            step(0, 0, 32'h0);
            guard++;
        end while (pend_cnt < 2 && guard < 40);
        @(posedge clk);
        #2;
        rst    = 1'b1;
        mem_en = 1'b0;
        #1;
        check("async_rst_valid", {31'd0, out_valid}, 32'd0);
        check("async_rst_pc", PC, 32'd0);
        check("async_rst_instr", Instruction, 32'd0);
        check("async_rst_addr", bus.imem_addr, RST_PC);
        release_reset();
        repeat (4) step(0, 0, 32'h0);
        check("stale_rsp_ignored", {31'd0, out_valid}, 32'd0);
        mem_en = 1'b1;

        // Randomized traffic.
        gnt_pct  = 70;
        n_before = n_consumed;
        for (int i = 0; i < 2000; i++) begin
            tgt = $urandom & 32'h0000_3FFF;
            if (($urandom % 8) == 0) tgt = 32'hFFFF_FFF0 | ($urandom & 32'hF);
            step((($urandom % 100) < 30) ? 1 : 0, (($urandom % 100) < 4) ? 1 : 0, tgt);
        end
        repeat (10) step(0, 0, 32'h0);
        checks++;
        if (n_consumed - n_before < 100) begin
            failures++;
            $display("FAIL random_progress: got %0d outputs expected >= 100", n_consumed - n_before);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: got no finish expected completion");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
